// File: rtl/report_sequencer.sv
// Frame sequencer: snapshots NCH channels, feeds each through the shared serial
// bin2bcd converter and hands the resulting ASCII digits, separators and CR LF to TX8.
module report_sequencer #(
    parameter int NCH         = 6,
    parameter int NNARROW     = 3,
    parameter int CONV_CYCLES = 26
) (
    input  logic              clk24M,
    input  logic              rst_n,
    input  logic [NCH*24-1:0] meas_data,
    input  logic              enable,
    output logic              bcd_rst,
    output logic              bcd_in,
    input  logic [31:0]       bcd_out,
    output logic [7:0]        tx_data,
    output logic              tx_start,
    input  logic              tx_busy,
    output logic              frame_busy,
    output logic              frame_done
);

    localparam int CW = 3;
    localparam int KW = 5;
    localparam logic [CW-1:0] LAST_CH = CW'(NCH - 1);
    localparam logic [KW-1:0] LAST_K  = KW'(CONV_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SNAP = 3'd1,
        S_LOAD = 3'd2,
        S_CONV = 3'd3,
        S_SEND = 3'd4,
        S_SEP  = 3'd5,
        S_CR   = 3'd6,
        S_LF   = 3'd7
    } state_t;

    function automatic logic [7:0] digit_ascii(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return 8'h30 + {4'h0, nib};
        end else begin
            return 8'h37 + {4'h0, nib};
        end
    endfunction

    state_t              state_q, state_d;
    logic [CW-1:0]       ch_q, ch_d;
    logic [2:0]          dig_q, dig_d;
    logic [KW-1:0]       k_q, k_d;
    logic [NCH*24-1:0]   snap_q, snap_d;
    logic [31:0]         bcd_reg_q, bcd_reg_d;
    logic [7:0]          tx_data_q, tx_data_d;
    logic                tx_start_q, tx_start_d;
    logic                bcd_rst_q, bcd_rst_d;
    logic                bcd_in_q, bcd_in_d;
    logic                frame_busy_q, frame_busy_d;
    logic                frame_done_q, frame_done_d;

    logic                can_issue_s;
    logic                wide_s;
    logic [2:0]          top_dig_s;
    logic [2:0]          pos_s;
    logic [3:0]          nib_s;
    logic [23:0]         snap_word_s;

    // Digit selection for the channel currently being printed
    always_comb begin
        can_issue_s = !tx_busy && !tx_start_q;
        wide_s      = ({1'b0, ch_q} >= 4'(NNARROW));
        top_dig_s   = wide_s ? 3'd7 : 3'd3;
        pos_s       = top_dig_s - dig_q;
        nib_s       = bcd_reg_q[{pos_s, 2'b00} +: 4];
    end

    // Next-state and byte-issue logic
    always_comb begin
        state_d      = state_q;
        ch_d         = ch_q;
        dig_d        = dig_q;
        k_d          = k_q;
        snap_d       = snap_q;
        bcd_reg_d    = bcd_reg_q;
        tx_data_d    = tx_data_q;
        tx_start_d   = 1'b0;
        frame_done_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    state_d = S_SNAP;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SNAP: begin
                snap_d  = meas_data;
                ch_d    = {CW{1'b0}};
                state_d = S_LOAD;
            end
            S_LOAD: begin
                k_d     = {KW{1'b0}};
                dig_d   = 3'd0;
                state_d = S_CONV;
            end
            S_CONV: begin
                if (k_q == LAST_K) begin
                    bcd_reg_d = bcd_out;
                    dig_d     = 3'd0;
                    state_d   = S_SEND;
                end else begin
                    k_d = k_q + 5'd1;
                end
            end
            S_SEND: begin
                if (can_issue_s) begin
                    tx_start_d = 1'b1;
                    tx_data_d  = digit_ascii(nib_s);
                    if (dig_q == top_dig_s) begin
                        dig_d   = 3'd0;
                        state_d = (ch_q == LAST_CH) ? S_CR : S_SEP;
                    end else begin
                        dig_d = dig_q + 3'd1;
                    end
                end else begin
                    state_d = S_SEND;
                end
            end
            S_SEP: begin
                if (can_issue_s) begin
                    tx_start_d = 1'b1;
                    tx_data_d  = 8'h2C;
                    ch_d       = ch_q + 3'd1;
                    state_d    = S_LOAD;
                end else begin
                    state_d = S_SEP;
                end
            end
            S_CR: begin
                if (can_issue_s) begin
                    tx_start_d = 1'b1;
                    tx_data_d  = 8'h0D;
                    state_d    = S_LF;
                end else begin
                    state_d = S_CR;
                end
            end
            S_LF: begin
                if (can_issue_s) begin
                    tx_start_d   = 1'b1;
                    tx_data_d    = 8'h0A;
                    frame_done_d = 1'b1;
                    // enable is only looked at here and in IDLE, so frames never truncate
                    state_d      = enable ? S_SNAP : S_IDLE;
                end else begin
                    state_d = S_LF;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Converter-side and status outputs, precomputed for the upcoming cycle
    always_comb begin
        snap_word_s = 24'h0;
        for (int c = 0; c < NCH; c++) begin
            snap_word_s = (ch_d == CW'(c)) ? snap_q[c*24 +: 24] : snap_word_s;
        end
        bcd_in_d     = ((state_d == S_CONV) && (k_d < 5'd24)) ? snap_word_s[5'd23 - k_d] : 1'b0;
        bcd_rst_d    = (state_d != S_CONV);
        frame_busy_d = (state_d != S_IDLE);
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk24M) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            ch_q         <= {CW{1'b0}};
            dig_q        <= 3'd0;
            k_q          <= {KW{1'b0}};
            snap_q       <= {(NCH*24){1'b0}};
            bcd_reg_q    <= 32'h0;
            tx_data_q    <= 8'h20;
            tx_start_q   <= 1'b0;
            bcd_rst_q    <= 1'b1;
            bcd_in_q     <= 1'b0;
            frame_busy_q <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ch_q         <= ch_d;
            dig_q        <= dig_d;
            k_q          <= k_d;
            snap_q       <= snap_d;
            bcd_reg_q    <= bcd_reg_d;
            tx_data_q    <= tx_data_d;
            tx_start_q   <= tx_start_d;
            bcd_rst_q    <= bcd_rst_d;
            bcd_in_q     <= bcd_in_d;
            frame_busy_q <= frame_busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bcd_rst    = bcd_rst_q;
    assign bcd_in     = bcd_in_q;
    assign tx_data    = tx_data_q;
    assign tx_start   = tx_start_q;
    assign frame_busy = frame_busy_q;
    assign frame_done = frame_done_q;

endmodule
